// File: rtl/ram_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data memory.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS ends a grant.
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t     state, next_state;
    logic [3:0] scnt, scnt_next;
    logic       dreq;
    logic       access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= next_state;
            scnt  <= scnt_next;
        end
    end

    always_comb begin
        next_state = state;
        scnt_next  = scnt;
        case (state)
            IDLE: begin
                if (dreq && (scnt < LIMIT)) begin
                    next_state = GNT_D;
                end else if (iREN) begin
                    next_state = GNT_I;
                end else if (dreq) begin
                    next_state = GNT_D;
                end
                // Count only data grants that actually make a pending fetch wait.
                if ((next_state == GNT_D) && iREN) begin
                    scnt_next = (scnt < LIMIT) ? scnt + 4'd1 : scnt;
                end else if ((next_state == GNT_I) || !iREN) begin
                    scnt_next = '0;
                end
            end
            GNT_I: begin
                if (!iREN || access) begin
                    next_state = IDLE;
                end
            end
            GNT_D: begin
                if (!dreq || access) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Enables follow the live request so a withdrawn request drops them immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            GNT_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
            end
            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            default: begin
            end
        endcase
    end

    assign iwait = iREN & ~((state == GNT_I) & access);
    assign dwait = dreq & ~((state == GNT_D) & access);
    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic checked against
// an ownership/starvation model of the arbitration rules.
module tb_ram_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = RS_FREE;

    int nvec = 0;
    int nerr = 0;

    // Model: who owns the RAM (0 nobody, 1 fetch, 2 data) and how many data
    // grants have been handed out while a fetch was waiting.
    int owner = 0;
    int starved = 0;

    ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic        want_d;
        logic        done;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        want_d  = dREN | dWEN;
        done    = (ramstate == RS_ACCESS);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        if (owner == 1) begin
            e_ren  = iREN;
            e_addr = iaddr;
        end else if (owner == 2) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
        end
        chk("ramREN", ramREN, 32'(e_ren));
        chk("ramWEN", ramWEN, 32'(e_wen));
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iwait", iwait, 32'(iREN && !(owner == 1 && done)));
        chk("dwait", dwait, 32'(want_d && !(owner == 2 && done)));
        chk("iload", iload, ramload);
        chk("dload", dload, ramload);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                         input logic [1:0] rs);
        @(negedge CLK);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramload = rl; ramstate = rs;
        #1;
        model_check();
    endtask

    task automatic step();
        bit want_d;
        bit done;
        @(posedge CLK);
        if (!nRST) begin
            owner   = 0;
            starved = 0;
        end else begin
            want_d = dREN || dWEN;
            done   = (ramstate == RS_ACCESS);
            if (owner == 0) begin
                if (want_d && (starved < LIMIT || !iREN)) begin
                    owner = 2;
                    starved = iREN ? ((starved + 1 > LIMIT) ? LIMIT : starved + 1) : 0;
                end else if (iREN) begin
                    owner = 1;
                    starved = 0;
                end else begin
                    starved = 0;
                end
            end else if (owner == 1) begin
                if (!iREN || done) owner = 0;
            end else begin
                if (!want_d || done) owner = 0;
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        owner = 0;
        starved = 0;
        drive(1, 32'h44, 1, 1, 32'h88, 32'h99, 32'h0, RS_ACCESS);
        chk("rst_ramREN", ramREN, 32'h0);
        chk("rst_iwait", iwait, 32'h1);
        chk("rst_dwait", dwait, 32'h1);
        step();
        #2 nRST = 1'b1;
    endtask

    initial begin
        do_reset();

        // Fetch only, zero-wait RAM
        drive(1, 32'h100, 0, 0, 0, 0, 32'h8C010004, RS_FREE);
        step();
        drive(1, 32'h100, 0, 0, 0, 0, 32'h8C010004, RS_ACCESS);
        chk("fetch_ramREN", ramREN, 32'h1);
        chk("fetch_ramaddr", ramaddr, 32'h100);
        chk("fetch_iwait", iwait, 32'h0);
        chk("fetch_iload", iload, 32'h8C010004);
        step();
        drive(1, 32'h104, 0, 0, 0, 0, 32'h0, RS_ACCESS);
        chk("fetch_bubble_ramREN", ramREN, 32'h0);
        step();

        // Contention: data first, fetch two cycles later
        do_reset();
        drive(1, 32'h400, 0, 1, 32'h200, 32'hDEADBEEF, 0, RS_FREE);
        step();
        drive(1, 32'h400, 0, 1, 32'h200, 32'hDEADBEEF, 0, RS_ACCESS);
        chk("cont_ramWEN", ramWEN, 32'h1);
        chk("cont_ramstore", ramstore, 32'hDEADBEEF);
        chk("cont_ramaddr", ramaddr, 32'h200);
        chk("cont_dwait", dwait, 32'h0);
        chk("cont_iwait", iwait, 32'h1);
        step();
        drive(1, 32'h400, 0, 0, 0, 0, 0, RS_ACCESS);
        chk("cont_bubble", ramREN, 32'h0);
        step();
        drive(1, 32'h400, 0, 0, 0, 0, 32'h1234, RS_ACCESS);
        chk("cont_fetch_ramREN", ramREN, 32'h1);
        chk("cont_fetch_ramaddr", ramaddr, 32'h400);
        chk("cont_fetch_iwait", iwait, 32'h0);
        step();

        // Flush abort while RAM busy
        do_reset();
        drive(1, 32'h500, 0, 0, 0, 0, 0, RS_FREE);
        step();
        drive(1, 32'h500, 0, 0, 0, 0, 0, RS_BUSY);
        chk("flush_ramREN_busy", ramREN, 32'h1);
        chk("flush_iwait_busy", iwait, 32'h1);
        step();
        drive(0, 32'h500, 0, 0, 0, 0, 0, RS_BUSY);
        chk("flush_ramREN_drop", ramREN, 32'h0);
        chk("flush_iwait_drop", iwait, 32'h0);
        step();
        drive(1, 32'h504, 0, 0, 0, 0, 0, RS_ACCESS);
        chk("flush_idle_ramREN", ramREN, 32'h0);
        chk("flush_idle_iwait", iwait, 32'h1);
        step();
        drive(1, 32'h504, 0, 0, 0, 0, 0, RS_ACCESS);
        chk("flush_regrant", ramREN, 32'h1);
        step();

        // Error retry on a data read
        do_reset();
        drive(0, 0, 1, 0, 32'h600, 0, 32'h1234, RS_FREE);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 32'h600, 0, 32'h1234, RS_ERROR);
            chk("err_dwait", dwait, 32'h1);
            chk("err_ramREN", ramREN, 32'h1);
            chk("err_ramaddr", ramaddr, 32'h600);
            step();
        end
        drive(0, 0, 1, 0, 32'h600, 0, 32'h1234, RS_ACCESS);
        chk("err_done_dwait", dwait, 32'h0);
        chk("err_done_dload", dload, 32'h1234);
        step();
        drive(0, 0, 1, 0, 32'h600, 0, 32'h1234, RS_ACCESS);
        chk("err_after_dwait", dwait, 32'h1);
        chk("err_after_ramREN", ramREN, 32'h0);
        step();

        // Reset asserted mid data write, with the starvation count already raised
        do_reset();
        drive(1, 32'h700, 0, 1, 32'h300, 32'h55AA, 0, RS_FREE);
        step();
        drive(1, 32'h700, 0, 1, 32'h300, 32'h55AA, 0, RS_BUSY);
        chk("midrst_ramWEN_before", ramWEN, 32'h1);
        #1 nRST = 1'b0;
        #1;
        owner = 0;
        starved = 0;
        model_check();
        chk("midrst_ramWEN", ramWEN, 32'h0);
        chk("midrst_ramaddr", ramaddr, 32'h0);
        chk("midrst_dwait", dwait, 32'h1);
        step();
        #2 nRST = 1'b1;

        // Starvation: exactly LIMIT data completions, then a fetch, repeating
        for (int c = 0; c < 20; c++) begin
            drive(1, 32'h800, 1, 0, 32'h900 + 32'(c), 0, 32'(c), RS_ACCESS);
            chk("starve_iwait", iwait, (c == 9 || c == 19) ? 32'h0 : 32'h1);
            chk("starve_dwait", dwait, (c % 2 == 1 && c != 9 && c != 19) ? 32'h0 : 32'h1);
            step();
        end

        // Random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] rs;
            case ($urandom_range(0, 7))
                0: rs = RS_FREE;
                1: rs = RS_BUSY;
                2: rs = RS_ERROR;
                default: rs = RS_ACCESS;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom, rs);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
